fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the control unit: owns the PC, issues requests to instruction memory, and holds the fetched word in an instruction register.
- Exposes the opcode field and bit 20 of the held word to the control unit.
- Applies redirects from the branch/jump resolution logic.
- Freezes permanently when the control unit deasserts its PC-load enable (EBREAK).
- Multicycle: at most one instruction per two cycles.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0013, word held in the instruction register whenever no valid instruction is present (addi x0,x0,0).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- imem_req  out  1  instruction-memory request, level; held until imem_ready.
- imem_addr  out  32  word-aligned fetch address; equals pc while imem_req=1.
- imem_rdata  in  32  instruction word; valid when imem_ready=1.
- imem_ready  in  1  memory response strobe; may assert in the same cycle as imem_req.
- stall  in  1  downstream not ready; holds the current instruction.
- pc_load  in  1  from control unit; 0 means the held instruction is EBREAK, so halt.
- redirect  in  1  branch/JAL/JALR taken for the held instruction.
- redirect_target  in  32  new PC when redirect=1.
- inst  out  32  held instruction word.
- inst_pc  out  32  address of the held instruction.
- inst_valid  out  1  inst/inst_pc hold a real fetched instruction.
- inst6to0  out  7  inst[6:0], opcode to control unit.
- inst20  out  1  inst[20], EBREAK/ECALL discriminator to control unit.
- halted  out  1  stage frozen by EBREAK.

Behaviour:
- States: IDLE, FETCH, HOLD, HALT. All state is reset asynchronously when rst=0.
- Reset values:
  - state=IDLE, pc=RESET_PC, inst=NOP_INST, inst_pc=RESET_PC.
  - inst_valid=0, halted=0, imem_req=0, imem_addr=RESET_PC.
- IDLE: imem_req=0. Next cycle goes to FETCH unconditionally, so the first request is issued one cycle after reset release.
- FETCH:
  - imem_req=1, imem_addr={pc[31:2],2'b00}.
  - When imem_ready=1 at a clock edge: inst<=imem_rdata, inst_pc<=pc, inst_valid<=1, pc<=pc+4 (32-bit wrap, 32'hFFFF_FFFC+4=0), then go to HOLD.
  - Otherwise stay in FETCH with address and request stable.
- HOLD: inst_valid=1, imem_req=0. Priority at each edge, highest first:
  1. stall=1: stay; inst, inst_pc and pc unchanged; pc_load and redirect ignored.
  2. pc_load=0: go to HALT; inst<=NOP_INST; inst_valid<=0; halted<=1.
  3. redirect=1: pc<={redirect_target[31:2],2'b00}; go to FETCH; inst<=NOP_INST; inst_valid<=0.
  4. Otherwise: go to FETCH (pc already incremented); inst<=NOP_INST; inst_valid<=0.
- HALT:
  - imem_req=0, inst_valid=0, halted=1, inst=NOP_INST.
  - All inputs are ignored; only reset exits.
- When inst_valid=0, inst is always NOP_INST. The control unit therefore sees an immediate-format op writing x0, with pc_load=1 and no memory side effects.
- inst6to0 and inst20 are pure slices of the inst register, with no added latency.
- imem_ready outside FETCH is ignored. A late response after reset or a halt has no effect.
- Reset asserted mid-FETCH abandons the request immediately: imem_req drops asynchronously.
- Redirect targets with bits[1:0]!=0 are force-aligned; no misalignment exception is raised.
- Throughput with zero-wait memory: 2 cycles per instruction. Each memory wait cycle adds 1.

Decomposition:
- Shared package riscv_pkg holds:
  - fetch state encoding (IDLE=2'd0, FETCH=2'd1, HOLD=2'd2, HALT=2'd3);
  - NOP_INST constant;
  - opcode constants (OP_SYSTEM=7'b1110011 etc.), reused by the control unit.
- One natural sub-module: pc_next, a combinational next-PC mux (pc+4 vs aligned redirect_target). The PC register stays in fetch_unit.

Test Plan:
- Reset release, imem_ready tied 1, rdata 32'h00500093 then 32'h00A00113:
  - imem_req rises 1 cycle after release with addr 0x0, then 0x4;
  - inst_valid pulses every 2nd cycle;
  - inst6to0=7'b0010011.
- imem_ready delayed 3 cycles at addr 0x8: imem_addr stays 0x8 and imem_req stays 1 for 4 cycles; inst_valid=0 throughout; captured word correct.
- stall=1 for 5 cycles while holding 0x00A00113 at inst_pc=0x4: inst/inst_pc unchanged and no imem_req; after release the next fetch is at 0x8.
- HOLD with redirect=1, target 0x0000_0123: next imem_addr=0x0000_0120, inst_pc of the next instruction=0x120, and no fetch at pc+4.
- Held word 32'h00100073 (EBREAK) with pc_load=0:
  - halted=1, inst_valid=0, imem_req stays 0 for 20 cycles despite redirect=1;
  - rst pulse restarts at RESET_PC.
- rst asserted while in FETCH waiting; imem_ready pulses 1 cycle after release (in IDLE): response ignored, fresh fetch at RESET_PC, inst=NOP_INST until the new response.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: fetch-stage state encoding, the canonical
// NOP word, and the major opcode values decoded by the control unit.
package riscv_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2,
      HALT  = 2'd3
   } fetch_state_t;

   // addi x0,x0,0 : harmless filler whenever no real instruction is held
   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and instruction memory (slave).
interface fetch_unit_if;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ready;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_rdata,
      input  imem_ready
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_rdata,
      output imem_ready
   );

endinterface

// File: rtl/pc_next.sv
// Combinational next-PC selection: sequential pc+4 or a word-aligned
// redirect target. The PC register itself lives in fetch_unit.
module pc_next
   import riscv_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [31:0] redirect_target,
   input  logic        take_redirect,
   output logic [31:0] next_pc
);

   // Misaligned targets are silently forced onto a word boundary
   always_comb begin
      next_pc = pc + 32'd4;
      if (take_redirect) begin
         next_pc = redirect_target & 32'hFFFF_FFFC;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Multicycle instruction-fetch stage: owns the PC, requests words from
// instruction memory, and holds the fetched word for the control unit.
// At most one instruction every two cycles; EBREAK freezes it until reset.
module fetch_unit
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = riscv_pkg::NOP_INST
)(
   input  logic              clk,
   input  logic              rst,
   fetch_unit_if.master      imem,
   input  logic              stall,
   input  logic              pc_load,
   input  logic              redirect,
   input  logic [31:0]       redirect_target,
   output logic [31:0]       inst,
   output logic [31:0]       inst_pc,
   output logic              inst_valid,
   output logic [6:0]        inst6to0,
   output logic              inst20,
   output logic              halted
);

   fetch_state_t state;
   logic [31:0]  pc;
   logic [31:0]  nextPc;
   logic         reqQ;
   logic         takeRedirect;

   assign takeRedirect = (state == HOLD) && redirect;

   pc_next u_pc_next (
      .pc              (pc),
      .redirect_target (redirect_target),
      .take_redirect   (takeRedirect),
      .next_pc         (nextPc)
   );

   assign imem.imem_req  = reqQ;
   assign imem.imem_addr = pc & 32'hFFFF_FFFC;

   assign inst6to0 = inst[6:0];
   assign inst20   = inst[20];

   // Fetch sequencer: all state and outputs are registered here; reset
   // abandons any pending request at once since reqQ clears asynchronously
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         pc         <= RESET_PC;
         inst       <= NOP_INST;
         inst_pc    <= RESET_PC;
         inst_valid <= 1'b0;
         halted     <= 1'b0;
         reqQ       <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               state <= FETCH;
               reqQ  <= 1'b1;
            end
            FETCH: begin
               if (imem.imem_ready) begin
                  inst       <= imem.imem_rdata;
                  inst_pc    <= pc;
                  inst_valid <= 1'b1;
                  pc         <= nextPc;
                  reqQ       <= 1'b0;
                  state      <= HOLD;
               end
            end
            HOLD: begin
               if (stall) begin
                  state <= HOLD;
               end else if (!pc_load) begin
                  state      <= HALT;
                  inst       <= NOP_INST;
                  inst_valid <= 1'b0;
                  halted     <= 1'b1;
               end else begin
                  if (redirect) begin
                     pc <= nextPc;
                  end
                  state      <= FETCH;
                  inst       <= NOP_INST;
                  inst_valid <= 1'b0;
                  reqQ       <= 1'b1;
               end
            end
            HALT: begin
               state <= HALT;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit. Scenarios run back to back and each
// continues from the state the previous one left behind. Inputs change on
// the falling edge; outputs are sampled on the falling edge.
module tb_fetch_unit;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        pc_load;
   logic        redirect;
   logic [31:0] redirect_target;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_valid;
   logic [6:0]  inst6to0;
   logic        inst20;
   logic        halted;

   int checks;
   int failures;

   localparam logic [31:0] NOP = 32'h0000_0013;

   fetch_unit_if imem_bus ();

   fetch_unit #(
      .RESET_PC (32'h0000_0000),
      .NOP_INST (32'h0000_0013)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .imem            (imem_bus.master),
      .stall           (stall),
      .pc_load         (pc_load),
      .redirect        (redirect),
      .redirect_target (redirect_target),
      .inst            (inst),
      .inst_pc         (inst_pc),
      .inst_valid      (inst_valid),
      .inst6to0        (inst6to0),
      .inst20          (inst20),
      .halted          (halted)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One full cycle: cross the active edge, land on the sampling edge
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      stall = 1'b0;
      pc_load = 1'b1;
      redirect = 1'b0;
      redirect_target = 32'h0;
      imem_bus.imem_ready = 1'b0;
      imem_bus.imem_rdata = 32'h0;
      tick();
      tick();
      checks++; if (imem_bus.imem_req !== 1'b0) begin failures++; $display("[TB] FAIL reset_req got=%0b exp=0", imem_bus.imem_req); end
      checks++; if (imem_bus.imem_addr !== 32'h0) begin failures++; $display("[TB] FAIL reset_addr got=%h exp=00000000", imem_bus.imem_addr); end
      checks++; if (inst !== NOP) begin failures++; $display("[TB] FAIL reset_inst got=%h exp=%h", inst, NOP); end
      checks++; if (inst_pc !== 32'h0) begin failures++; $display("[TB] FAIL reset_inst_pc got=%h exp=00000000", inst_pc); end
      checks++; if (inst_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%0b exp=0", inst_valid); end
      checks++; if (halted !== 1'b0) begin failures++; $display("[TB] FAIL reset_halted got=%0b exp=0", halted); end
      checks++; if (inst6to0 !== 7'b0010011) begin failures++; $display("[TB] FAIL reset_opcode got=%b exp=0010011", inst6to0); end
   endtask

   task automatic test_zero_wait();
      imem_bus.imem_ready = 1'b1;
      imem_bus.imem_rdata = 32'h0050_0093;
      rst = 1'b1;
      checks++; if (imem_bus.imem_req !== 1'b0) begin failures++; $display("[TB] FAIL idle_req got=%0b exp=0", imem_bus.imem_req); end
      tick();
      checks++; if (imem_bus.imem_req !== 1'b1) begin failures++; $display("[TB] FAIL first_req got=%0b exp=1", imem_bus.imem_req); end
      checks++; if (imem_bus.imem_addr !== 32'h0) begin failures++; $display("[TB] FAIL first_addr got=%h exp=00000000", imem_bus.imem_addr); end
      checks++; if (inst_valid !== 1'b0) begin failures++; $display("[TB] FAIL first_fetch_valid got=%0b exp=0", inst_valid); end
      tick();
      checks++; if (inst_valid !== 1'b1) begin failures++; $display("[TB] FAIL first_hold_valid got=%0b exp=1", inst_valid); end
      checks++; if (inst !== 32'h0050_0093) begin failures++; $display("[TB] FAIL first_inst got=%h exp=00500093", inst); end
      checks++; if (inst6to0 !== 7'b0010011) begin failures++; $display("[TB] FAIL first_opcode got=%b exp=0010011", inst6to0); end
      checks++; if (imem_bus.imem_req !== 1'b0) begin failures++; $display("[TB] FAIL hold_req got=%0b exp=0", imem_bus.imem_req); end
      imem_bus.imem_rdata = 32'h00A0_0113;
      tick();
      checks++; if (imem_bus.imem_addr !== 32'h4 || imem_bus.imem_req !== 1'b1) begin failures++; $display("[TB] FAIL second_addr got=%h req=%0b exp=00000004 req=1", imem_bus.imem_addr, imem_bus.imem_req); end
      checks++; if (inst_valid !== 1'b0 || inst !== NOP) begin failures++; $display("[TB] FAIL gap_nop got=%h valid=%0b exp=%h valid=0", inst, inst_valid, NOP); end
      tick();
      checks++; if (inst !== 32'h00A0_0113 || inst_pc !== 32'h4 || inst_valid !== 1'b1) begin failures++; $display("[TB] FAIL second_inst got=%h pc=%h valid=%0b exp=00a00113 pc=00000004 valid=1", inst, inst_pc, inst_valid); end
   endtask

   task automatic test_stall();
      stall = 1'b1;
      imem_bus.imem_ready = 1'b0;
      redirect = 1'b1;
      redirect_target = 32'h0000_0400;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++; if (inst !== 32'h00A0_0113 || inst_pc !== 32'h4 || imem_bus.imem_req !== 1'b0 || inst_valid !== 1'b1) begin failures++; $display("[TB] FAIL stall_hold cyc=%0d got=%h pc=%h req=%0b valid=%0b exp=00a00113 pc=00000004 req=0 valid=1", i, inst, inst_pc, imem_bus.imem_req, inst_valid); end
      end
      stall = 1'b0;
      redirect = 1'b0;
      tick();
      checks++; if (imem_bus.imem_addr !== 32'h8 || imem_bus.imem_req !== 1'b1) begin failures++; $display("[TB] FAIL post_stall_addr got=%h req=%0b exp=00000008 req=1", imem_bus.imem_addr, imem_bus.imem_req); end
   endtask

   task automatic test_wait_states();
      // First FETCH cycle at 0x8 was already sampled; two more with no response
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++; if (imem_bus.imem_addr !== 32'h8 || imem_bus.imem_req !== 1'b1 || inst_valid !== 1'b0) begin failures++; $display("[TB] FAIL wait_cycle cyc=%0d addr=%h req=%0b valid=%0b exp=00000008 req=1 valid=0", i, imem_bus.imem_addr, imem_bus.imem_req, inst_valid); end
      end
      imem_bus.imem_ready = 1'b1;
      imem_bus.imem_rdata = 32'h0080_006F;
      tick();
      checks++; if (inst !== 32'h0080_006F || inst_pc !== 32'h8 || inst_valid !== 1'b1) begin failures++; $display("[TB] FAIL wait_capture got=%h pc=%h valid=%0b exp=0080006f pc=00000008 valid=1", inst, inst_pc, inst_valid); end
   endtask

   task automatic test_redirect();
      imem_bus.imem_ready = 1'b0;
      redirect = 1'b1;
      redirect_target = 32'h0000_0123;
      tick();
      checks++; if (imem_bus.imem_addr !== 32'h120 || imem_bus.imem_req !== 1'b1) begin failures++; $display("[TB] FAIL redirect_addr got=%h req=%0b exp=00000120 req=1", imem_bus.imem_addr, imem_bus.imem_req); end
      redirect = 1'b0;
      imem_bus.imem_ready = 1'b1;
      imem_bus.imem_rdata = 32'h0010_0073;
      tick();
      checks++; if (inst_pc !== 32'h120 || inst !== 32'h0010_0073) begin failures++; $display("[TB] FAIL redirect_inst got=%h pc=%h exp=00100073 pc=00000120", inst, inst_pc); end
      checks++; if (inst20 !== 1'b1 || inst6to0 !== 7'b1110011) begin failures++; $display("[TB] FAIL ebreak_fields got=%b/%0b exp=1110011/1", inst6to0, inst20); end
   endtask

   task automatic test_halt();
      pc_load = 1'b0;
      tick();
      pc_load = 1'b1;
      redirect = 1'b1;
      redirect_target = 32'h0000_0040;
      imem_bus.imem_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         checks++; if (halted !== 1'b1 || inst_valid !== 1'b0 || imem_bus.imem_req !== 1'b0 || inst !== NOP) begin failures++; $display("[TB] FAIL halt_frozen cyc=%0d halted=%0b valid=%0b req=%0b inst=%h exp=1/0/0/%h", i, halted, inst_valid, imem_bus.imem_req, inst, NOP); end
         tick();
      end
      redirect = 1'b0;
      imem_bus.imem_ready = 1'b0;
      rst = 1'b0;
      #1;
      checks++; if (halted !== 1'b0 || imem_bus.imem_addr !== 32'h0) begin failures++; $display("[TB] FAIL halt_reset halted=%0b addr=%h exp=0 00000000", halted, imem_bus.imem_addr); end
      @(negedge clk);
      rst = 1'b1;
      tick();
      checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h0) begin failures++; $display("[TB] FAIL restart_fetch req=%0b addr=%h exp=1 00000000", imem_bus.imem_req, imem_bus.imem_addr); end
   endtask

   task automatic test_reset_mid_fetch();
      // Still in FETCH at 0x0 waiting on memory
      tick();
      #2;
      rst = 1'b0;
      #1;
      checks++; if (imem_bus.imem_req !== 1'b0) begin failures++; $display("[TB] FAIL async_req_drop got=%0b exp=0", imem_bus.imem_req); end
      @(negedge clk);
      rst = 1'b1;
      imem_bus.imem_ready = 1'b1;
      imem_bus.imem_rdata = 32'hDEAD_BEEF;
      tick();
      imem_bus.imem_ready = 1'b0;
      checks++; if (inst !== NOP || inst_valid !== 1'b0) begin failures++; $display("[TB] FAIL late_resp_ignored got=%h valid=%0b exp=%h valid=0", inst, inst_valid, NOP); end
      checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h0) begin failures++; $display("[TB] FAIL fresh_fetch req=%0b addr=%h exp=1 00000000", imem_bus.imem_req, imem_bus.imem_addr); end
      tick();
      checks++; if (inst !== NOP || inst_valid !== 1'b0) begin failures++; $display("[TB] FAIL nop_until_resp got=%h valid=%0b exp=%h valid=0", inst, inst_valid, NOP); end
      imem_bus.imem_ready = 1'b1;
      imem_bus.imem_rdata = 32'h0050_0093;
      tick();
      checks++; if (inst !== 32'h0050_0093 || inst_pc !== 32'h0 || inst_valid !== 1'b1) begin failures++; $display("[TB] FAIL refetch_capture got=%h pc=%h valid=%0b exp=00500093 pc=00000000 valid=1", inst, inst_pc, inst_valid); end
   endtask

   task automatic test_wrap();
      redirect = 1'b1;
      redirect_target = 32'hFFFF_FFFF;
      imem_bus.imem_rdata = 32'h1111_1093;
      tick();
      redirect = 1'b0;
      checks++; if (imem_bus.imem_addr !== 32'hFFFF_FFFC || imem_bus.imem_req !== 1'b1) begin failures++; $display("[TB] FAIL wrap_top_addr got=%h req=%0b exp=fffffffc req=1", imem_bus.imem_addr, imem_bus.imem_req); end
      tick();
      checks++; if (inst_pc !== 32'hFFFF_FFFC || inst !== 32'h1111_1093) begin failures++; $display("[TB] FAIL wrap_capture got=%h pc=%h exp=11111093 pc=fffffffc", inst, inst_pc); end
      tick();
      checks++; if (imem_bus.imem_addr !== 32'h0 || imem_bus.imem_req !== 1'b1) begin failures++; $display("[TB] FAIL wrap_zero_addr got=%h req=%0b exp=00000000 req=1", imem_bus.imem_addr, imem_bus.imem_req); end
   endtask

   // Scenario sequence, then the single summary line
   initial begin
      checks = 0;
      failures = 0;
      @(negedge clk);
      test_reset();
      test_zero_wait();
      test_stall();
      test_wait_states();
      test_redirect();
      test_halt();
      test_reset_mid_fetch();
      test_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
